// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle WIDTH-bit unsigned magnitude comparator.
// Feeds one shared 2-bit slice, MSB pair first, behind a start/busy/done handshake.
// Optional build macro: COMPARATOR_SEQ_EARLY_EXIT_EN
//   defined   -> stop on the first unequal slice (1..N cycles to decision)
//   undefined -> always walk all N slices (constant time); the first
//                unequal slice is remembered in a sticky register

module comparator2bit (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic       gt_o,
  output logic       eq_o,
  output logic       lt_o
);
  // Pure combinational 2-bit unsigned compare
  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i < b_i);
endmodule

module comparator_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int unsigned N     = WIDTH / 2;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
  logic               stk_vld_q, stk_vld_d;
  logic               stk_gt_q, stk_gt_d;
`endif

  logic sl_gt, sl_eq, sl_lt;
  logic last_slice;

  comparator2bit u_slice (
    .a_i  (sa_q[WIDTH-1 -: 2]),
    .b_i  (sb_q[WIDTH-1 -: 2]),
    .gt_o (sl_gt),
    .eq_o (sl_eq),
    .lt_o (sl_lt)
  );

  assign last_slice = (idx_q == IDX_W'(N - 1));

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
    stk_vld_d = stk_vld_q;
    stk_gt_d  = stk_gt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          idx_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
          stk_vld_d = 1'b0;
          stk_gt_d  = 1'b0;
`endif
          state_d = CMP;
        end
      end

      CMP: begin
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
        if (sl_gt || sl_lt) begin
          gt_d    = sl_gt;
          lt_d    = sl_lt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (last_slice) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << 2;
          sb_d  = sb_q << 2;
          idx_d = idx_q + IDX_W'(1);
        end
`else
        if (last_slice) begin
          // Earlier unequal slice wins; otherwise the last slice decides
          if (stk_vld_q) begin
            gt_d = stk_gt_q;
            lt_d = ~stk_gt_q;
            eq_d = 1'b0;
          end else begin
            gt_d = sl_gt;
            lt_d = sl_lt;
            eq_d = sl_eq;
          end
          state_d = DONE;
        end else begin
          if (!stk_vld_q && !sl_eq) begin
            stk_vld_d = 1'b1;
            stk_gt_d  = sl_gt;
          end
          sa_d  = sa_q << 2;
          sb_d  = sb_q << 2;
          idx_d = idx_q + IDX_W'(1);
        end
`endif
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
      stk_vld_q <= 1'b0;
      stk_gt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
      stk_vld_q <= stk_vld_d;
      stk_gt_q  <= stk_gt_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_eq_b = eq_q;
  assign a_lt_b = lt_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq (WIDTH=8, N=4).
module tb_comparator_seq;

  localparam int unsigned WIDTH = 8;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy, done, a_gt_b, a_eq_b, a_lt_b;

  int n_chk  = 0;
  int n_fail = 0;

  comparator_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one compare, wait for done, check latency, flags and teardown
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic eg, input logic ee, input logic el, input int k_ee);
    int k;
    int k_exp;
    k_exp = EE ? k_ee : 4;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_E0"}, busy, 1);
    chk({tag, "_flags_clear"}, {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, k, k_exp);
    chk({tag, "_flags"}, {a_gt_b, a_eq_b, a_lt_b}, {eg, ee, el});
    chk({tag, "_busy_in_done"}, busy, 1);
    @(posedge clk); #1;
    chk({tag, "_done_falls"}, done, 0);
    chk({tag, "_busy_falls"}, busy, 0);
    chk({tag, "_flags_hold"}, {a_gt_b, a_eq_b, a_lt_b}, {eg, ee, el});
  endtask

  initial begin
    int k;
    int dcount;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_outputs", {busy, done, a_gt_b, a_eq_b, a_lt_b}, 5'b00000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, done, a_gt_b, a_eq_b, a_lt_b}, 5'b00000);

    run_cmp("eq_a5",   8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 4);
    run_cmp("gt_80",   8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1);
    run_cmp("lt_12",   8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4);
    run_cmp("lt_00ff", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1);
    run_cmp("gt_ff00", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    run_cmp("eq_00",   8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 4);
    run_cmp("gt_c3",   8'hC3, 8'hC1, 1'b1, 1'b0, 1'b0, 4);
    run_cmp("lt_mid",  8'h5A, 8'h6A, 1'b0, 1'b0, 1'b1, 2);

    // Second start during CMP with changed operand is ignored
    @(negedge clk);
    a = 8'h55; b = 8'h56; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; dcount = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ign_done", done, 1);
    chk("ign_latency", k, 4);
    chk("ign_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b001);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("ign_single_done", dcount, 0);
    chk("ign_idle_busy", busy, 0);

    // Reset in the middle of CMP
    @(negedge clk);
    a = 8'h40; b = 8'h41; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {busy, done, a_gt_b, a_eq_b, a_lt_b}, 5'b00000);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("rst_no_done", dcount, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_idle", {busy, done, a_gt_b, a_eq_b, a_lt_b}, 5'b00000);
    run_cmp("post_rst_gt", 8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
